// File: rtl/serdesphy_bringup_sequencer.sv
// serdesphy_bringup_sequencer: timed PLL/CDR reset sequencing with lock timeouts, bounded retries and filtered loss-of-lock recovery
module serdesphy_bringup_sequencer #(
    parameter int RST_HOLD    = 16,
    parameter int PLL_TIMEOUT = 300,
    parameter int CDR_TIMEOUT = 1500,
    parameter int LOCK_FILTER = 4,
    parameter int MAX_RETRY   = 2
) (
    input  logic       clk_ref_24m,
    input  logic       rst,
    input  logic       start,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    output logic       phy_en,
    output logic       pll_rst,
    output logic       cdr_rst,
    output logic       seq_ready,
    output logic       seq_fault,
    output logic       lol_event,
    output logic [1:0] retry_cnt,
    output logic [2:0] seq_state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLL_RST  = 3'd1,
        PLL_WAIT = 3'd2,
        CDR_RST  = 3'd3,
        CDR_WAIT = 3'd4,
        READY    = 3'd5,
        FAULT    = 3'd6
    } state_t;

    localparam logic [11:0] HOLD_END  = 12'(RST_HOLD - 1);
    localparam logic [11:0] PLL_END   = 12'(PLL_TIMEOUT - 1);
    localparam logic [11:0] CDR_END   = 12'(CDR_TIMEOUT - 1);
    localparam logic [3:0]  FLT_END   = 4'(LOCK_FILTER - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [11:0] timer_q, timer_d;
    logic [3:0]  pll_flt_q, pll_flt_d, cdr_flt_q, cdr_flt_d;
    logic [1:0]  retry_q, retry_d;
    logic        phy_en_q, phy_en_d, pll_rst_q, pll_rst_d, cdr_rst_q, cdr_rst_d;
    logic        ready_q, ready_d, fault_q, fault_d, lol_q, lol_d;
    logic        pll_watch, cdr_watch, pll_loss, cdr_loss, timeout;

    // Next state, timer, lock-loss filters, retry bookkeeping and output decode of the next state
    always_comb begin
        pll_watch = state_q == CDR_WAIT || state_q == READY;
        cdr_watch = state_q == READY;
        pll_flt_d = (pll_watch && !pll_lock) ? pll_flt_q + 4'd1 : 4'd0;
        cdr_flt_d = (cdr_watch && !cdr_lock) ? cdr_flt_q + 4'd1 : 4'd0;
        pll_loss  = pll_watch && !pll_lock && pll_flt_q == FLT_END;
        cdr_loss  = cdr_watch && !cdr_lock && cdr_flt_q == FLT_END;
        timeout   = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE:     state_d = PLL_RST;
            PLL_RST:  state_d = (timer_q == HOLD_END) ? PLL_WAIT : PLL_RST;
            PLL_WAIT: begin
                state_d = pll_lock ? CDR_RST : PLL_WAIT;
                timeout = !pll_lock && timer_q == PLL_END;
            end
            CDR_RST:  state_d = (timer_q == HOLD_END) ? CDR_WAIT : CDR_RST;
            CDR_WAIT: begin
                state_d = pll_loss ? PLL_RST : cdr_lock ? READY : CDR_WAIT;
                timeout = !pll_loss && !cdr_lock && timer_q == CDR_END;
            end
            READY:    state_d = pll_loss ? PLL_RST : cdr_loss ? CDR_RST : READY;
            default:  state_d = FAULT;
        endcase
        retry_d = retry_q;
        if (timeout) begin
            state_d = (retry_q == RETRY_MAX) ? FAULT : PLL_RST;
            retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + 2'd1;
        end
        if (!start) state_d = IDLE;
        if (state_d == IDLE || (state_d == READY && state_q != READY)) retry_d = 2'd0;
        lol_d     = start && (pll_loss || cdr_loss);
        timer_d   = (state_d != state_q) ? 12'd0 :
                    (state_q inside {PLL_RST, PLL_WAIT, CDR_RST, CDR_WAIT}) ? timer_q + 12'd1 : timer_q;
        phy_en_d  = !(state_d inside {IDLE, FAULT});
        pll_rst_d = state_d inside {IDLE, PLL_RST, FAULT};
        cdr_rst_d = !(state_d inside {CDR_WAIT, READY});
        ready_d   = state_d == READY;
        fault_d   = state_d == FAULT;
    end

    // Registers state, counters and outputs together so outputs always match seq_state
    always_ff @(posedge clk_ref_24m) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= 12'd0;
            pll_flt_q <= 4'd0;
            cdr_flt_q <= 4'd0;
            retry_q   <= 2'd0;
            phy_en_q  <= 1'b0;
            pll_rst_q <= 1'b1;
            cdr_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            lol_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pll_flt_q <= pll_flt_d;
            cdr_flt_q <= cdr_flt_d;
            retry_q   <= retry_d;
            phy_en_q  <= phy_en_d;
            pll_rst_q <= pll_rst_d;
            cdr_rst_q <= cdr_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            lol_q     <= lol_d;
        end
    end

    assign phy_en    = phy_en_q;
    assign pll_rst   = pll_rst_q;
    assign cdr_rst   = cdr_rst_q;
    assign seq_ready = ready_q;
    assign seq_fault = fault_q;
    assign lol_event = lol_q;
    assign retry_cnt = retry_q;
    assign seq_state = state_q;
endmodule

// File: tb/tb_serdesphy_bringup_sequencer.sv
// tb_serdesphy_bringup_sequencer: vector table plus randomized run against a timestamp-based reference model
module tb_serdesphy_bringup_sequencer;
    localparam int RST_HOLD = 16;
    localparam int PLL_TO   = 300;
    localparam int CDR_TO   = 1500;
    localparam int LF       = 4;
    localparam int MAXR     = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, pll_lock = 1'b0, cdr_lock = 1'b0;
    logic       phy_en, pll_rst, cdr_rst, seq_ready, seq_fault, lol_event;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    int vectors = 0, miscompares = 0;

    // Reference model: absolute cycle stamps instead of counters
    int cyc = 0, m_state = 0, m_retry = 0, m_ent = 0;
    int p_low = 0, p_win = 0, c_low = 0, c_win = 0;
    bit m_lol = 1'b0;

    typedef struct {
        bit r, s, pl, cl;
        int n;
        int st, rc;
        bit rdy, flt;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    serdesphy_bringup_sequencer #(
        .RST_HOLD(RST_HOLD), .PLL_TIMEOUT(PLL_TO), .CDR_TIMEOUT(CDR_TO),
        .LOCK_FILTER(LF), .MAX_RETRY(MAXR)
    ) dut (
        .clk_ref_24m(clk), .rst(rst), .start(start), .pll_lock(pll_lock), .cdr_lock(cdr_lock),
        .phy_en(phy_en), .pll_rst(pll_rst), .cdr_rst(cdr_rst), .seq_ready(seq_ready),
        .seq_fault(seq_fault), .lol_event(lol_event), .retry_cnt(retry_cnt), .seq_state(seq_state)
    );

    function automatic logic [10:0] exp_word();
        bit phy, pr, cr;
        phy = !(m_state == 0 || m_state == 6);
        pr  = m_state == 0 || m_state == 1 || m_state == 6;
        cr  = !(m_state == 4 || m_state == 5);
        return {phy, pr, cr, m_state == 5, m_state == 6, m_lol, 2'(m_retry), 3'(m_state)};
    endfunction

    task automatic model_step(input bit r, input bit s, input bit pl, input bit cl);
        int ns, el, prun, crun;
        bit to;
        ns    = m_state;
        to    = 1'b0;
        m_lol = 1'b0;
        el    = cyc - m_ent;
        prun  = (!pl && (m_state == 4 || m_state == 5)) ? cyc - ((p_low > p_win) ? p_low : p_win) + 1 : 0;
        crun  = (!cl && m_state == 5) ? cyc - ((c_low > c_win) ? c_low : c_win) + 1 : 0;
        if (r) begin
            ns = 0;
            m_retry = 0;
        end else if (!s) ns = 0;
        else case (m_state)
            0: ns = 1;
            1: if (el == RST_HOLD - 1) ns = 2;
            2: if (pl) ns = 3; else if (el == PLL_TO - 1) to = 1'b1;
            3: if (el == RST_HOLD - 1) ns = 4;
            4: if (prun >= LF) begin ns = 1; m_lol = 1'b1; end
               else if (cl) ns = 5;
               else if (el == CDR_TO - 1) to = 1'b1;
            5: if (prun >= LF) begin ns = 1; m_lol = 1'b1; end
               else if (crun >= LF) begin ns = 3; m_lol = 1'b1; end
            default: ;
        endcase
        if (to) begin
            if (m_retry == MAXR) ns = 6;
            else begin m_retry++; ns = 1; end
        end
        if (ns == 0 || (ns == 5 && m_state != 5)) m_retry = 0;
        if (ns != m_state) begin
            m_ent = cyc + 1;
            if (ns == 4) p_win = cyc + 1;
            if (ns == 5) c_win = cyc + 1;
        end
        if (pl) p_low = cyc + 1;
        if (cl) c_low = cyc + 1;
        m_state = ns;
        cyc++;
    endtask

    task automatic tick(input bit r, input bit s, input bit pl, input bit cl);
        logic [10:0] got, exp;
        rst = r; start = s; pll_lock = pl; cdr_lock = cl;
        @(posedge clk);
        model_step(r, s, pl, cl);
        #1;
        got = {phy_en, pll_rst, cdr_rst, seq_ready, seq_fault, lol_event, retry_cnt, seq_state};
        exp = exp_word();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL cycle %0d outputs {phy,pll_rst,cdr_rst,rdy,flt,lol,retry,state} got=%b exp=%b", cyc, got, exp);
        end
    endtask

    task automatic add(input bit r, input bit s, input bit pl, input bit cl, input int n,
                       input int st, input int rc, input bit rdy, input bit flt);
        vec_t v;
        v.r = r; v.s = s; v.pl = pl; v.cl = cl; v.n = n;
        v.st = st; v.rc = rc; v.rdy = rdy; v.flt = flt;
        tbl.push_back(v);
    endtask

    initial begin
        bit s, pl, cl, r;
        int len;
        //  r  s  pl cl  n     st rc rdy flt
        add(1, 0, 0, 0, 2,    0, 0, 0, 0);
        add(0, 1, 0, 0, 1,    1, 0, 0, 0);
        add(0, 1, 0, 0, 15,   1, 0, 0, 0);
        add(0, 1, 0, 0, 1,    2, 0, 0, 0);
        add(0, 1, 0, 0, 240,  2, 0, 0, 0);
        add(0, 1, 1, 0, 1,    3, 0, 0, 0);
        add(0, 1, 1, 0, 16,   4, 0, 0, 0);
        add(0, 1, 1, 0, 500,  4, 0, 0, 0);
        add(0, 1, 1, 1, 1,    5, 0, 1, 0);
        add(0, 1, 1, 0, 3,    5, 0, 1, 0);
        add(0, 1, 1, 1, 1,    5, 0, 1, 0);
        add(0, 1, 1, 0, 4,    3, 0, 0, 0);
        add(0, 1, 1, 0, 16,   4, 0, 0, 0);
        add(0, 1, 1, 1, 1,    5, 0, 1, 0);
        add(0, 1, 0, 1, 4,    1, 0, 0, 0);
        add(0, 0, 0, 1, 1,    0, 0, 0, 0);
        add(0, 1, 0, 0, 1,    1, 0, 0, 0);
        add(0, 1, 0, 0, 16,   2, 0, 0, 0);
        add(0, 1, 0, 0, 299,  2, 0, 0, 0);
        add(0, 1, 0, 0, 1,    1, 1, 0, 0);
        add(0, 1, 0, 0, 316,  1, 2, 0, 0);
        add(0, 1, 0, 0, 316,  6, 2, 0, 1);
        add(0, 1, 0, 0, 5,    6, 2, 0, 1);
        add(0, 0, 0, 0, 1,    0, 0, 0, 0);
        add(0, 1, 0, 0, 17,   2, 0, 0, 0);
        add(0, 1, 0, 0, 299,  2, 0, 0, 0);
        add(0, 1, 1, 0, 1,    3, 0, 0, 0);
        add(0, 0, 0, 0, 1,    0, 0, 0, 0);
        add(0, 1, 0, 0, 17,   2, 0, 0, 0);
        add(0, 1, 0, 0, 100,  2, 0, 0, 0);
        add(0, 0, 0, 0, 1,    0, 0, 0, 0);
        add(0, 1, 0, 0, 16,   1, 0, 0, 0);
        add(0, 1, 0, 0, 1,    2, 0, 0, 0);
        add(0, 1, 1, 0, 1,    3, 0, 0, 0);
        add(0, 1, 1, 0, 16,   4, 0, 0, 0);
        add(0, 1, 1, 1, 1,    5, 0, 1, 0);
        add(1, 1, 1, 1, 1,    0, 0, 0, 0);
        add(0, 1, 1, 1, 1,    1, 0, 0, 0);
        add(0, 1, 1, 1, 16,   2, 0, 0, 0);
        add(0, 1, 1, 1, 1,    3, 0, 0, 0);
        add(0, 1, 1, 1, 16,   4, 0, 0, 0);
        add(0, 1, 1, 1, 1,    5, 0, 1, 0);
        add(0, 1, 0, 0, 4,    1, 0, 0, 0);
        add(0, 1, 1, 0, 16,   2, 0, 0, 0);
        add(0, 1, 1, 0, 1,    3, 0, 0, 0);
        add(0, 1, 1, 0, 16,   4, 0, 0, 0);
        add(0, 1, 0, 0, 4,    1, 0, 0, 0);
        add(0, 1, 1, 0, 16,   2, 0, 0, 0);
        add(0, 1, 1, 0, 1,    3, 0, 0, 0);
        add(0, 1, 1, 0, 16,   4, 0, 0, 0);
        add(0, 1, 1, 0, 1499, 4, 0, 0, 0);
        add(0, 1, 1, 0, 1,    1, 1, 0, 0);
        add(0, 0, 0, 0, 1,    0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].r, tbl[i].s, tbl[i].pl, tbl[i].cl);
            vectors++;
            if ({seq_state, retry_cnt, seq_ready, seq_fault} !== {3'(tbl[i].st), 2'(tbl[i].rc), tbl[i].rdy, tbl[i].flt}) begin
                miscompares++;
                $display("FAIL row %0d {state,retry,rdy,flt} got=%0d,%0d,%0b,%0b exp=%0d,%0d,%0b,%0b", i,
                         seq_state, retry_cnt, seq_ready, seq_fault, tbl[i].st, tbl[i].rc, tbl[i].rdy, tbl[i].flt);
            end
        end

        for (int ep = 0; ep < 200; ep++) begin
            s   = $urandom_range(0, 15) != 0;
            pl  = $urandom_range(0, 3) != 0;
            cl  = $urandom_range(0, 2) != 0;
            r   = $urandom_range(0, 40) == 0;
            len = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : $urandom_range(7, 400);
            for (int k = 0; k < len; k++) tick(r && k == 0, s, pl, cl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
